// File: rtl/alu32.sv
// alu32: registered integer ALU for the single-cycle MIPS datapath.
// Each rising clk edge samples a, b and op. The selected function is computed
// combinationally, and the result, zero flag and signed-overflow flag are
// registered together, so outputs reflect the operands of the previous edge.
module alu32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow
);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_INC = 3'b010,
    OP_DEC = 3'b011,
    OP_NOT = 3'b100,
    OP_XOR = 3'b101,
    OP_AND = 3'b110,
    OP_OR  = 3'b111
  } op_e;

  localparam int               MSB     = WIDTH - 1;
  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_result;
  logic             w_overflow;
  op_e              w_op;

  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_overflow;

  // Shared adder/subtractor outputs; carry-out is dropped so results wrap.
  assign w_sum  = a + b;
  assign w_diff = a - b;
  assign w_op   = op_e'(op);

  // Next-state result and signed-overflow selection by opcode.
  always_comb begin
    // NOTE: defaults assigned before the case keep this block free of inferred latches.
    w_result   = '0;
    w_overflow = 1'b0;
    unique case (w_op)
      OP_ADD: begin
        w_result   = w_sum;
        w_overflow = (a[MSB] == b[MSB]) && (w_sum[MSB] != a[MSB]);
      end
      OP_SUB: begin
        w_result   = w_diff;
        w_overflow = (a[MSB] != b[MSB]) && (w_diff[MSB] != a[MSB]);
      end
      OP_INC: begin
        // Only the largest positive value overflows when incremented.
        w_result   = b + ONE;
        w_overflow = (b == MAX_POS);
      end
      OP_DEC: begin
        // Only the most negative value overflows when decremented.
        w_result   = b - ONE;
        w_overflow = (b == MIN_NEG);
      end
      OP_NOT: w_result = ~a;
      OP_XOR: w_result = a ^ b;
      OP_AND: w_result = a & b;
      OP_OR:  w_result = a | b;
    endcase
  end

  // Output registers; zero is derived from the same-cycle result, not the stale one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: non-blocking assignments model the flops so every register samples pre-edge values.
      r_result   <= '0;
      r_zero     <= 1'b1;
      r_overflow <= 1'b0;
    end else begin
      r_result   <= w_result;
      r_zero     <= (w_result == '0);
      r_overflow <= w_overflow;
    end
  end

  assign result   = r_result;
  assign zero     = r_zero;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_alu32.sv
// tb_alu32: self-checking bench for alu32. Directed vector table, randomized
// operands against an integer-arithmetic reference model, back-to-back opcode
// sweep, and asynchronous reset sequences.
module tb_alu32;

  logic        clk;
  logic        rst_n;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  op;
  logic [31:0] result;
  logic        zero;
  logic        overflow;

  int n_checks = 0;
  int n_fail   = 0;

  alu32 #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a        (a),
    .b        (b),
    .op       (op),
    .result   (result),
    .zero     (zero),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [31:0] r;
    logic        z;
    logic        v;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string name, input logic [31:0] r, input logic z, input logic v);
    check({name, ".result"},   result,          r);
    check({name, ".zero"},     {31'b0, zero},   {31'b0, z});
    check({name, ".overflow"}, {31'b0, overflow}, {31'b0, v});
  endtask

  // Reference model: signed operands widened to 64 bits, overflow is simply
  // "true result does not fit in 32-bit two's complement".
  function automatic void model(input logic [31:0] ma, input logic [31:0] mb, input logic [2:0] mop,
                                output logic [31:0] r, output logic v);
    longint sa;
    longint sb;
    longint s;
    sa = longint'($signed(ma));
    sb = longint'($signed(mb));
    s  = 0;
    v  = 1'b0;
    case (mop)
      3'd0: s = sa + sb;
      3'd1: s = sa - sb;
      3'd2: s = sb + 1;
      3'd3: s = sb - 1;
      default: s = 0;
    endcase
    if (mop < 3'd4) begin
      v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      r = s[31:0];
    end else begin
      case (mop)
        3'd4:    r = ~ma;
        3'd5:    r = ma ^ mb;
        3'd6:    r = ma & mb;
        default: r = ma | mb;
      endcase
    end
  endfunction

  // Drive at the falling edge, then sample just after the next rising edge.
  task automatic apply(input logic [31:0] ta, input logic [31:0] tb, input logic [2:0] top);
    @(negedge clk);
    a  = ta;
    b  = tb;
    op = top;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] corners[6];
    corners = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0001};
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 5)];
    return $urandom;
  endfunction

  initial begin
    logic [31:0] er;
    logic        ev;
    logic [31:0] prev_r;
    logic        prev_z;
    logic        prev_v;

    vecs[0]  = '{"add_1_1",     32'h1,         32'h1,         3'b000, 32'h2,         1'b0, 1'b0};
    vecs[1]  = '{"sub_1_1",     32'h1,         32'h1,         3'b001, 32'h0,         1'b1, 1'b0};
    vecs[2]  = '{"add_ovf",     32'h7FFF_FFFF, 32'h1,         3'b000, 32'h8000_0000, 1'b0, 1'b1};
    vecs[3]  = '{"sub_ovf",     32'h8000_0000, 32'h1,         3'b001, 32'h7FFF_FFFF, 1'b0, 1'b1};
    vecs[4]  = '{"inc_1",       32'h0,         32'h1,         3'b010, 32'h2,         1'b0, 1'b0};
    vecs[5]  = '{"dec_1",       32'h0,         32'h1,         3'b011, 32'h0,         1'b1, 1'b0};
    vecs[6]  = '{"inc_ovf",     32'h0,         32'h7FFF_FFFF, 3'b010, 32'h8000_0000, 1'b0, 1'b1};
    vecs[7]  = '{"inc_wrap",    32'h0,         32'hFFFF_FFFF, 3'b010, 32'h0,         1'b1, 1'b0};
    vecs[8]  = '{"not_9",       32'h9,         32'h1234_5678, 3'b100, 32'hFFFF_FFF6, 1'b0, 1'b0};
    vecs[9]  = '{"xor_1_2",     32'h1,         32'h2,         3'b101, 32'h3,         1'b0, 1'b0};
    vecs[10] = '{"and_1_1",     32'h1,         32'h1,         3'b110, 32'h1,         1'b0, 1'b0};
    vecs[11] = '{"and_1_0",     32'h1,         32'h0,         3'b110, 32'h0,         1'b1, 1'b0};
    vecs[12] = '{"or_1_0",      32'h1,         32'h0,         3'b111, 32'h1,         1'b0, 1'b0};
    vecs[13] = '{"or_0_0",      32'h0,         32'h0,         3'b111, 32'h0,         1'b1, 1'b0};
    vecs[14] = '{"dec_ovf",     32'h0,         32'h8000_0000, 3'b011, 32'h7FFF_FFFF, 1'b0, 1'b1};

    // Reset held with live inputs and a running clock.
    rst_n = 1'b0;
    a = 32'd5;
    b = 32'd7;
    op = 3'b000;
    repeat (3) @(posedge clk);
    #1;
    check_outs("reset_hold", 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_outs("reset_release", 32'd12, 1'b0, 1'b0);

    // Directed vectors.
    for (int i = 0; i < 15; i++) begin
      apply(vecs[i].a, vecs[i].b, vecs[i].op);
      check_outs(vecs[i].name, vecs[i].r, vecs[i].z, vecs[i].v);
    end

    // Randomized operands against the reference model.
    for (int i = 0; i < 300; i++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      logic [2:0]  rop;
      ra  = pick();
      rb  = pick();
      rop = 3'($urandom_range(0, 7));
      model(ra, rb, rop, er, ev);
      apply(ra, rb, rop);
      check_outs($sformatf("rand%0d_op%0d", i, rop), er, (er == 32'h0), ev);
    end

    // Back-to-back sweep: outputs must hold until the edge, then update.
    model(32'h0, 32'h0, 3'b111, prev_r, prev_v);
    apply(32'h0, 32'h0, 3'b111);
    prev_z = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      a  = 32'h1234_5678;
      b  = 32'h0F0F_0F0F + 32'(k);
      op = 3'(k);
      #1;
      check_outs($sformatf("b2b_hold%0d", k), prev_r, prev_z, prev_v);
      model(a, b, op, er, ev);
      @(posedge clk);
      #1;
      check_outs($sformatf("b2b_op%0d", k), er, (er == 32'h0), ev);
      prev_r = er;
      prev_z = (er == 32'h0);
      prev_v = ev;
    end

    // Asynchronous reset pulsed mid-cycle while clk is high.
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_outs("async_clear", 32'h0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    check_outs("async_hold", 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    a  = 32'h7FFF_FFFF;
    b  = 32'h1;
    op = 3'b000;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_outs("async_release", 32'h8000_0000, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu32.md
Name: alu32

Overview:
- Registered 32-bit integer ALU for the single-cycle MIPS datapath.
- Each clock edge it samples operands `a`/`b` and a 3-bit opcode, computes one of eight arithmetic/logic functions, and registers the result.
- Outputs are a result word, a zero flag and a signed-overflow flag.
- Purely datapath: no handshake, no internal state beyond the output registers.

Parameters:
- WIDTH, 32, operand/result width in bits. All behaviour below is stated for WIDTH; tests use 32.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst_n  input  1  reset, asynchronous assert, active-low
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- op  input  3  operation select
- result  output  WIDTH  registered operation result
- zero  output  1  registered flag, 1 when the registered result is all zeros
- overflow  output  1  registered signed (two's complement) overflow flag

Behaviour:
- Reset:
  - rst_n low forces result=0, zero=1 and overflow=0 immediately, without waiting for clk.
  - Outputs hold these values while rst_n is low.
  - The first rising clk edge after rst_n goes high loads normal results.
  - Reset asserted mid-stream discards the in-flight computation.
- Latency: exactly 1 cycle. Inputs sampled at rising edge N appear on outputs right after edge N. A new operation is accepted every cycle.
- Opcode map (all arithmetic is modulo 2^WIDTH; carry-out is discarded):
  - 000 ADD: a + b
  - 001 SUB: a - b
  - 010 INC: b + 1
  - 011 DEC: b - 1
  - 100 NOT: ~a (b ignored)
  - 101 XOR: a ^ b
  - 110 AND: a & b
  - 111 OR: a | b
- zero: set to 1 exactly when the next result value equals 0, for every opcode including logic ops. It is computed from the same-cycle result, never from a stale one.
- overflow, signed interpretation of operands:
  - ADD: a[MSB]==b[MSB] and sum[MSB]!=a[MSB]
  - SUB: a[MSB]!=b[MSB] and diff[MSB]!=a[MSB]
  - INC: set only when b = 0x7FFFFFFF
  - DEC: set only when b = 0x80000000
  - NOT/XOR/AND/OR: always 0
- Wrap-around: results wrap without saturation, e.g. 0xFFFFFFFF + 1 = 0 with zero=1, overflow=0.
- No X propagation: every op value maps to a defined function, so there is no default/illegal case.
- Flags and result always update together, at the same edge.

Test Plan:
- Reset check: rst_n=0 with a=5, b=7, op=000 and clk toggling -> result=0, zero=1, overflow=0. Release rst_n; after the next edge result=12, zero=0.
- ADD/SUB:
  - a=1, b=1, op=000 -> result=2, zero=0.
  - a=1, b=1, op=001 -> result=0, zero=1.
  - a=0x7FFFFFFF, b=1, op=000 -> result=0x80000000, overflow=1.
  - a=0x80000000, b=1, op=001 -> result=0x7FFFFFFF, overflow=1.
- INC/DEC:
  - b=1, op=010 -> 2.
  - b=1, op=011 -> 0, zero=1.
  - b=0x7FFFFFFF, op=010 -> 0x80000000, overflow=1.
  - b=0xFFFFFFFF, op=010 -> 0, zero=1, overflow=0.
- Logic ops:
  - a=0x9, op=100 -> 0xFFFFFFF6.
  - a=1, b=2, op=101 -> 3.
  - a=1, b=1, op=110 -> 1.
  - a=1, b=0, op=110 -> 0, zero=1.
  - a=1, b=0, op=111 -> 1.
  - a=0, b=0, op=111 -> 0, zero=1.
  - overflow=0 in every logic case.
- Back-to-back and async reset: change op every cycle through all eight codes and confirm each result appears exactly one edge later. Then pulse rst_n low between clock edges -> outputs clear immediately, mid-cycle.
